// File: rtl/stq_pkg.sv
// Shared definitions for the store-queue allocation controller.
//   STQ_BUF_COUNT : number of store-queue entries (power of two)
//   STQ_PTR_W     : log2(STQ_BUF_COUNT); pointers carry one extra wrap bit
package stq_pkg;

  localparam int unsigned STQ_BUF_COUNT = 32;
  localparam int unsigned STQ_PTR_W     = 5;

  typedef logic [STQ_PTR_W:0]       stq_ptr_t;  // index plus wrap bit
  typedef logic [STQ_PTR_W-1:0]     stq_idx_t;  // entry index
  typedef logic [STQ_BUF_COUNT-1:0] stq_vec_t;  // one bit per entry

endpackage

// File: rtl/stq_range_mask.sv
// Combinational range decoder: sets mask bit i for every entry index in the
// modular range [start_ptr, end_ptr). Pointers carry a wrap bit, so a range
// covering the whole queue (end - start == BUF_COUNT) yields all ones.
//   start_ptr : first pointer of the range (inclusive)
//   end_ptr   : last pointer of the range (exclusive)
//   mask      : BUF_COUNT-bit entry mask
module stq_range_mask
  import stq_pkg::*;
#(
  parameter int unsigned PTR_W     = STQ_PTR_W,
  parameter int unsigned BUF_COUNT = 1 << PTR_W
) (
  input  logic [PTR_W:0]     start_ptr,
  input  logic [PTR_W:0]     end_ptr,
  output logic [BUF_COUNT-1:0] mask
);

  logic [PTR_W:0]   len;
  logic [PTR_W-1:0] offs;

  // An entry is inside the range when its distance from start (mod
  // BUF_COUNT) is smaller than the range length.
  always_comb begin
    len  = end_ptr - start_ptr;
    mask = '0;
    offs = '0;
    for (int unsigned i = 0; i < BUF_COUNT; i++) begin
      offs    = PTR_W'(i) - start_ptr[PTR_W-1:0];
      mask[i] = ({1'b0, offs} < len);
    end
  end

endmodule

// File: rtl/stq_alloc_ctrl.sv
// Store-queue pointer and lifecycle controller.
// Allocates entries to up to two dispatched stores per cycle, commits the
// oldest entries on retirement, hands committed entries to the cache drain
// port one at a time and frees them on acknowledge; rewinds on exception.
//   clk, rst             : clock, asynchronous active-low reset
//   stallA, excpt        : dispatch stall, exception flush pulse
//   alloc0/1_req         : per-slot allocation requests
//   alloc_ok             : all requests this cycle granted (combinational)
//   alloc0/1_idx         : entry index offered to each slot
//   retire_cnt           : number of oldest stores retiring (0..2)
//   passe_en             : registered commit pulse per entry
//   drain_vld/idx/ack    : drain handshake towards the cache
//   free_en              : registered free pulse per entry
//   count, full, empty   : occupancy status
module stq_alloc_ctrl
  import stq_pkg::*;
#(
  parameter int unsigned BUF_COUNT = STQ_BUF_COUNT,
  parameter int unsigned PTR_W     = STQ_PTR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallA,
  input  logic                 excpt,
  input  logic                 alloc0_req,
  input  logic                 alloc1_req,
  output logic                 alloc_ok,
  output logic [PTR_W-1:0]     alloc0_idx,
  output logic [PTR_W-1:0]     alloc1_idx,
  input  logic [1:0]           retire_cnt,
  output logic [BUF_COUNT-1:0] passe_en,
  output logic                 drain_vld,
  output logic [PTR_W-1:0]     drain_idx,
  input  logic                 drain_ack,
  output logic [BUF_COUNT-1:0] free_en,
  output logic [PTR_W:0]       count,
  output logic                 full,
  output logic                 empty
);

  logic [PTR_W:0]       tail, cptr, dptr;
  logic [PTR_W:0]       cptr_nxt, dptr_nxt, free_slots, nreq, uncommitted;
  logic                 drain_fire;
  logic [BUF_COUNT-1:0] passe_mask, flush_mask, drain_mask, free_nxt;

  assign nreq        = (PTR_W+1)'(alloc0_req) + (PTR_W+1)'(alloc1_req);
  assign count       = tail - dptr;
  assign uncommitted = tail - cptr;
  assign free_slots  = (PTR_W+1)'(BUF_COUNT) - count;
  assign full        = (count == (PTR_W+1)'(BUF_COUNT));
  assign empty       = (count == '0);

  assign alloc_ok   = !stallA && !excpt && (free_slots >= nreq);
  assign alloc0_idx = tail[PTR_W-1:0];
  assign alloc1_idx = tail[PTR_W-1:0] + PTR_W'(alloc0_req);

  assign cptr_nxt   = cptr + (PTR_W+1)'(retire_cnt);
  assign drain_vld  = (dptr != cptr);
  assign drain_idx  = dptr[PTR_W-1:0];
  assign drain_fire = drain_vld && drain_ack;
  assign dptr_nxt   = dptr + (PTR_W+1)'(drain_fire);

  // Entries committed this cycle: [cptr, cptr').
  stq_range_mask #(.PTR_W(PTR_W), .BUF_COUNT(BUF_COUNT)) u_passe (
    .start_ptr (cptr),
    .end_ptr   (cptr_nxt),
    .mask      (passe_mask)
  );

  // Entries discarded by an exception: [cptr', tail).
  stq_range_mask #(.PTR_W(PTR_W), .BUF_COUNT(BUF_COUNT)) u_flush (
    .start_ptr (cptr_nxt),
    .end_ptr   (tail),
    .mask      (flush_mask)
  );

  // Entry drained this cycle: [dptr, dptr + drain_fire).
  stq_range_mask #(.PTR_W(PTR_W), .BUF_COUNT(BUF_COUNT)) u_drain (
    .start_ptr (dptr),
    .end_ptr   (dptr_nxt),
    .mask      (drain_mask)
  );

  // Drained entries lie in [dptr, cptr) and flushed ones in [cptr', tail),
  // so the two sources never overlap.
  assign free_nxt = drain_mask | (excpt ? flush_mask : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tail     <= '0;
      cptr     <= '0;
      dptr     <= '0;
      passe_en <= '0;
      free_en  <= '0;
    end else begin
      if (excpt)         tail <= cptr_nxt;
      else if (alloc_ok) tail <= tail + nreq;
      cptr     <= cptr_nxt;
      dptr     <= dptr_nxt;
      passe_en <= passe_mask;
      free_en  <= free_nxt;
    end
  end

  a_retire_legal : assert property (@(posedge clk) disable iff (!rst)
    (retire_cnt != 2'd3) && ((PTR_W+1)'(retire_cnt) <= uncommitted))
    else $error("retire_cnt %0d exceeds uncommitted entries %0d", retire_cnt, uncommitted);

endmodule

// File: tb/tb_stq_alloc_ctrl.sv
module tb_stq_alloc_ctrl;
  import stq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallA = 1'b0, excpt = 1'b0;
  logic        alloc0_req = 1'b0, alloc1_req = 1'b0;
  logic        alloc_ok;
  stq_idx_t    alloc0_idx, alloc1_idx, drain_idx;
  logic [1:0]  retire_cnt = 2'd0;
  stq_vec_t    passe_en, free_en;
  logic        drain_vld, drain_ack = 1'b0;
  stq_ptr_t    count;
  logic        full, empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stq_alloc_ctrl #(.BUF_COUNT(32), .PTR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .stallA     (stallA),
    .excpt      (excpt),
    .alloc0_req (alloc0_req),
    .alloc1_req (alloc1_req),
    .alloc_ok   (alloc_ok),
    .alloc0_idx (alloc0_idx),
    .alloc1_idx (alloc1_idx),
    .retire_cnt (retire_cnt),
    .passe_en   (passe_en),
    .drain_vld  (drain_vld),
    .drain_idx  (drain_idx),
    .drain_ack  (drain_ack),
    .free_en    (free_en),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic a0, input logic a1, input logic [1:0] rc,
                        input logic ack, input logic ex, input logic st);
    alloc0_req = a0; alloc1_req = a1; retire_cnt = rc;
    drain_ack = ack; excpt = ex; stallA = st;
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    int n;
    // ---- Reset state
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_drain_vld", drain_vld, 0);
    chk("rst_passe", passe_en, 0);
    chk("rst_free", free_en, 0);
    rst = 1'b1;
    cyc();

    // ---- Test 1: fill with paired allocations
    for (int i = 0; i < 16; i++) begin
      set_in(1, 1, 0, 0, 0, 0);
      #1;
      chk("t1_ok", alloc_ok, 1);
      chk("t1_idx0", alloc0_idx, 64'(2 * i));
      chk("t1_idx1", alloc1_idx, 64'(2 * i + 1));
      cyc();
    end
    chk("t1_count", count, 32);
    chk("t1_full", full, 1);
    chk("t1_empty", empty, 0);
    #1;
    chk("t1_17th_ok", alloc_ok, 0);
    cyc();
    chk("t1_17th_count", count, 32);
    chk("t1_17th_tail", alloc0_idx, 0);

    // ---- Test 2: commit, drain, free; ack while idle ignored
    do_reset();
    set_in(0, 0, 0, 1, 0, 0);
    #1;
    chk("t2_idle_vld", drain_vld, 0);
    cyc();
    chk("t2_idle_count", count, 0);
    chk("t2_idle_free", free_en, 0);
    set_in(1, 1, 0, 0, 0, 0);
    cyc();
    set_in(1, 0, 0, 0, 0, 0);
    #1;
    chk("t2_idx0", alloc0_idx, 2);
    chk("t2_idx1", alloc1_idx, 3);
    cyc();
    set_in(0, 0, 2, 0, 0, 0);
    cyc();
    chk("t2_passe", passe_en, 64'h3);
    chk("t2_drain_vld", drain_vld, 1);
    chk("t2_drain_idx", drain_idx, 0);
    chk("t2_count3", count, 3);
    set_in(0, 0, 0, 1, 0, 0);
    cyc();
    chk("t2_free", free_en, 64'h1);
    chk("t2_passe_pulse", passe_en, 0);
    chk("t2_count2", count, 2);
    chk("t2_drain_idx1", drain_idx, 1);

    // ---- Test 3: wrap at entry 31
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_in(1, 1, 0, 0, 0, 0);
      cyc();
    end
    set_in(1, 0, 0, 0, 0, 0);
    cyc();
    for (int i = 0; i < 15; i++) begin
      set_in(0, 0, 2, 0, 0, 0);
      cyc();
    end
    set_in(0, 0, 1, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 1, 0, 0);
    n = 0;
    while (drain_vld === 1'b1 && n < 64) begin
      cyc();
      n++;
    end
    set_in(0, 0, 0, 0, 0, 0);
    chk("t3_drained", drain_vld, 0);
    chk("t3_empty", empty, 1);
    chk("t3_drain_idx", drain_idx, 31);
    set_in(1, 1, 0, 0, 0, 0);
    #1;
    chk("t3_ok", alloc_ok, 1);
    chk("t3_idx0", alloc0_idx, 31);
    chk("t3_idx1", alloc1_idx, 0);
    cyc();
    set_in(0, 0, 2, 0, 0, 0);
    cyc();
    chk("t3_passe_wrap", passe_en, 64'h8000_0001);
    chk("t3_count", count, 2);

    // ---- Test 4: exception with same-cycle commit
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 0, 0, 0);
      cyc();
    end
    set_in(0, 0, 2, 0, 0, 0);
    cyc();
    set_in(1, 0, 1, 0, 1, 0);
    #1;
    chk("t4_excpt_ok", alloc_ok, 0);
    cyc();
    set_in(0, 0, 0, 0, 0, 0);
    chk("t4_passe", passe_en, 64'h4);
    chk("t4_free", free_en, 64'h38);
    chk("t4_count", count, 3);
    chk("t4_tail", alloc0_idx, 3);
    chk("t4_drain_vld", drain_vld, 1);
    chk("t4_drain_idx", drain_idx, 0);
    set_in(0, 0, 0, 1, 0, 0);
    cyc();
    chk("t4_free_drain", free_en, 64'h1);
    chk("t4_count2", count, 2);
    chk("t4_drain_idx1", drain_idx, 1);

    // ---- Test 5: stall blocks slot-1-only request
    set_in(0, 1, 0, 0, 0, 1);
    #1;
    chk("t5_stall_ok", alloc_ok, 0);
    chk("t5_stall_idx1", alloc1_idx, 3);
    cyc();
    chk("t5_stall_count", count, 2);
    set_in(0, 1, 0, 0, 0, 0);
    #1;
    chk("t5_ok", alloc_ok, 1);
    chk("t5_idx1", alloc1_idx, 3);
    cyc();
    chk("t5_tail", alloc0_idx, 4);
    chk("t5_count", count, 3);

    // ---- Test 6: asynchronous reset mid-drain
    set_in(1, 1, 1, 0, 0, 0);
    cyc();
    chk("t6_count", count, 5);
    chk("t6_passe", passe_en, 64'h8);
    chk("t6_drain_vld", drain_vld, 1);
    set_in(0, 0, 0, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_full", full, 0);
    chk("t6_rst_drain_vld", drain_vld, 0);
    chk("t6_rst_passe", passe_en, 0);
    chk("t6_rst_free", free_en, 0);
    chk("t6_rst_idx0", alloc0_idx, 0);
    set_in(0, 0, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stq_alloc_ctrl.md
Name: stq_alloc_ctrl

Overview:
Pointer and lifecycle controller for the 32-entry store-queue address CAM array. Allocates entries to dispatched stores and marks the oldest entries as committed when stores retire. Hands committed entries to the cache drain port, one at a time, and frees each entry once the drain is acknowledged. It generates the per-entry passe_en and free_en one-hot vectors that the CAM array consumes, and rewinds on exception.

Parameters:
BUF_COUNT, 32, number of store-queue entries (power of two)
PTR_W, 5, log2(BUF_COUNT); internal pointers carry PTR_W+1 bits (extra wrap bit)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
stallA  in  1  dispatch stall; no allocation while high
excpt  in  1  exception flush pulse
alloc0_req  in  1  slot-0 store requests an entry
alloc1_req  in  1  slot-1 store requests an entry
alloc_ok  out  1  all requests this cycle granted (combinational)
alloc0_idx  out  PTR_W  entry index for slot 0
alloc1_idx  out  PTR_W  entry index for slot 1
retire_cnt  in  2  oldest stores retiring this cycle (0..2; 3 is illegal)
passe_en  out  BUF_COUNT  one-hot/two-hot commit pulse to the entries (registered)
drain_vld  out  1  a committed entry awaits drain
drain_idx  out  PTR_W  entry index being drained
drain_ack  in  1  cache accepted the drain
free_en  out  BUF_COUNT  free pulse to the entries (registered)
count  out  PTR_W+1  allocated (not yet freed) entries
full  out  1  count==BUF_COUNT
empty  out  1  count==0

Behaviour:
- Three pointers, each PTR_W+1 bits: tail (next allocate), cptr (next to commit), dptr (next to drain). Invariant: dptr <= cptr <= tail, in modular order.
- Reset (rst low, async): tail=cptr=dptr=0. passe_en=0, free_en=0, count=0, empty=1, full=0, drain_vld=0.
- Allocation:
  - nreq = alloc0_req+alloc1_req.
  - alloc_ok = !stallA && !excpt && (BUF_COUNT-count) >= nreq.
  - alloc0_idx = tail[PTR_W-1:0].
  - alloc1_idx = tail+alloc0_req, so it equals tail when slot 0 is idle.
  - All-or-nothing: if alloc_ok, tail += nreq at the next edge; otherwise no grant and tail holds.
  - The index outputs are valid whenever requested, independent of alloc_ok.
- Commit:
  - retire_cnt=k sets passe_en bits cptr and cptr+1 (mod BUF_COUNT) as required, registered, as a one-cycle pulse the following cycle.
  - cptr += k.
  - retire_cnt greater than the number of uncommitted entries (tail-cptr) is illegal; flag it with an assertion.
- Drain:
  - drain_vld = (dptr != cptr), drain_idx = dptr[PTR_W-1:0].
  - When drain_vld && drain_ack: dptr += 1, and free_en bit dptr pulses on the next cycle.
  - drain_ack without drain_vld is ignored.
- count = tail - dptr, computed modulo 2^(PTR_W+1).
- Exception (excpt high at an edge):
  - Commit of that cycle happens first, giving cptr' = cptr + retire_cnt.
  - free_en pulses next cycle for every entry in [cptr', tail), with wrap handled.
  - tail <= cptr'. No allocation that cycle.
  - Committed entries (dptr..cptr') survive and keep draining; a same-cycle drain_ack is honoured.
- Simultaneous events:
  - Alloc, commit and drain in one cycle are all honoured.
  - A passe_en bit and a free_en bit never target the same entry in the same cycle, because drained entries were committed at least one cycle earlier.
- Wrap: pointer indices wrap at BUF_COUNT. Full and empty are told apart by the wrap bit.
- Reset mid-operation discards all state immediately; the output vectors clear asynchronously.

Decomposition:
- Shared package stq_pkg:
  - STQ_BUF_COUNT=32, STQ_PTR_W=5
  - typedef stq_ptr_t (PTR_W+1 bits), stq_idx_t (PTR_W bits), stq_vec_t (BUF_COUNT bits)
- One sub-module, stq_range_mask: combinational; given start/end pointers it produces the BUF_COUNT-bit mask of [start,end) with wrap. Used for the exception free_en vector and the passe_en decode.

Test Plan:
1. Reset, then alloc0_req=alloc1_req=1 for 16 cycles -> indices 0,1,...,30,31; full=1 after cycle 16; a 17th request gives alloc_ok=0 and tail holds.
2. Allocate 3 entries, retire_cnt=2 -> passe_en=32'h3 one cycle later; drain_vld=1, drain_idx=0; drain_ack -> free_en=32'h1 next cycle, count=2.
3. Wrap: set tail=cptr=dptr=31, allocate 2 -> indices 31 and 0; retire 2 -> passe_en=32'h8000_0001.
4. Allocate 6 entries, commit 2, drain 0; excpt with retire_cnt=1 the same cycle -> passe_en=32'h4, free_en=32'h38, tail=3, count=3, drain continues at 0.
5. alloc1_req only with stallA=1 -> alloc_ok=0; release stallA -> alloc1_idx=tail, tail+1.
6. Assert rst low mid-drain with count=5 -> all outputs clear immediately, empty=1, drain_vld=0.
